control: RTL and testbench

- Combinational microinstruction decoder for the SCAMP CPU.
- Takes the 16-bit microinstruction word from microcode ROM and drives the bus-output enables, bus-input (load) strobes, PC-increment, sequencer-reset, jump-condition enables and ALU function flags.
- Several outputs are active-low to drive '_bar' enable pins directly.

---
 rtl/control.sv | 100 ++++++++++
 tb/tb_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/control.sv
`default_nettype none
// ============================================================================
// Module   : control
// Purpose  : Combinational SCAMP microinstruction decoder driving bus enables,
//            load strobes, sequencer controls, jump enables and ALU flags.
// Revision : 1.0 - initial release
// ============================================================================
module control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] uinstr,
    output logic        EO_bar,
    output logic        PO_bar,
    output logic        IOH_bar,
    output logic        IOL_bar,
    output logic        RO,
    output logic        XO_bar,
    output logic        YO_bar,
    output logic        DO,
    output logic        RT,
    output logic        PP,
    output logic        MI,
    output logic        II_bar,
    output logic        RI,
    output logic        XI_bar,
    output logic        YI_bar,
    output logic        DI,
    output logic        JC,
    output logic        JZ,
    output logic        JGT,
    output logic        JLT,
    output logic [5:0]  ALU_flags
);

    // The decode has no state; the clock and reserved low bits are not consumed.
    logic w_unused;
    assign w_unused = ^{clk, uinstr[1:0]};

    always_comb begin
        EO_bar    = 1'b1;
        PO_bar    = 1'b1;
        IOH_bar   = 1'b1;
        IOL_bar   = 1'b1;
        RO        = 1'b0;
        XO_bar    = 1'b1;
        YO_bar    = 1'b1;
        DO        = 1'b0;
        RT        = 1'b0;
        PP        = 1'b0;
        MI        = 1'b0;
        II_bar    = 1'b1;
        RI        = 1'b0;
        XI_bar    = 1'b1;
        YI_bar    = 1'b1;
        DI        = 1'b0;
        JC        = 1'b0;
        JZ        = 1'b0;
        JGT       = 1'b0;
        JLT       = 1'b0;
        ALU_flags = 6'd0;

        if (!reset) begin
            EO_bar    = uinstr[15];
            ALU_flags = uinstr[14:9];

            // Bits 14:10 double as bus-source select and RT/PP when the ALU is off the bus.
            if (uinstr[15]) begin
                RT = uinstr[11];
                PP = uinstr[10];
                case (uinstr[14:12])
                    3'd0:    PO_bar  = 1'b0;
                    3'd1:    IOH_bar = 1'b0;
                    3'd2:    IOL_bar = 1'b0;
                    3'd3:    RO      = 1'b1;
                    3'd4:    XO_bar  = 1'b0;
                    3'd5:    YO_bar  = 1'b0;
                    3'd6:    DO      = 1'b1;
                    default: ;
                endcase
            end

            case (uinstr[8:6])
                3'd1:    MI     = 1'b1;
                3'd2:    II_bar = 1'b0;
                3'd3:    RI     = 1'b1;
                3'd4:    XI_bar = 1'b0;
                3'd5:    YI_bar = 1'b0;
                3'd6:    DI     = 1'b1;
                default: ;
            endcase

            JC  = uinstr[5];
            JZ  = uinstr[4];
            JGT = uinstr[3];
            JLT = uinstr[2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_control
// Purpose  : Scoreboard bench for the control microinstruction decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control;

    typedef struct packed {
        logic       EO_bar;
        logic       PO_bar;
        logic       IOH_bar;
        logic       IOL_bar;
        logic       RO;
        logic       XO_bar;
        logic       YO_bar;
        logic       DO;
        logic       RT;
        logic       PP;
        logic       MI;
        logic       II_bar;
        logic       RI;
        logic       XI_bar;
        logic       YI_bar;
        logic       DI;
        logic       JC;
        logic       JZ;
        logic       JGT;
        logic       JLT;
        logic [5:0] ALU_flags;
    } ctl_t;

    localparam ctl_t C_IDLE = '{EO_bar:1'b1, PO_bar:1'b1, IOH_bar:1'b1, IOL_bar:1'b1,
                                RO:1'b0, XO_bar:1'b1, YO_bar:1'b1, DO:1'b0,
                                RT:1'b0, PP:1'b0, MI:1'b0, II_bar:1'b1, RI:1'b0,
                                XI_bar:1'b1, YI_bar:1'b1, DI:1'b0,
                                JC:1'b0, JZ:1'b0, JGT:1'b0, JLT:1'b0, ALU_flags:6'd0};

    logic        clk;
    logic        reset;
    logic [15:0] uinstr;
    ctl_t        act;

    ctl_t  exp_q[$];
    string name_q[$];
    int    n_checks;
    int    n_fail;

    control u_dut (
        .clk       (clk),
        .reset     (reset),
        .uinstr    (uinstr),
        .EO_bar    (act.EO_bar),
        .PO_bar    (act.PO_bar),
        .IOH_bar   (act.IOH_bar),
        .IOL_bar   (act.IOL_bar),
        .RO        (act.RO),
        .XO_bar    (act.XO_bar),
        .YO_bar    (act.YO_bar),
        .DO        (act.DO),
        .RT        (act.RT),
        .PP        (act.PP),
        .MI        (act.MI),
        .II_bar    (act.II_bar),
        .RI        (act.RI),
        .XI_bar    (act.XI_bar),
        .YI_bar    (act.YI_bar),
        .DI        (act.DI),
        .JC        (act.JC),
        .JZ        (act.JZ),
        .JGT       (act.JGT),
        .JLT       (act.JLT),
        .ALU_flags (act.ALU_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one vector is applied per cycle, sampled at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    end

    task automatic apply(input logic r, input logic [15:0] u, input ctl_t e, input string n);
        @(posedge clk);
        #1;
        reset  = r;
        uinstr = u;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    initial begin
        ctl_t e;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        uinstr   = 16'hFFFF;

        apply(1'b1, 16'hFFFF, C_IDLE, "reset_all_ones");

        e = C_IDLE; e.PO_bar = 1'b0;
        apply(1'b0, 16'h8000, e, "po_only");

        e = C_IDLE; e.EO_bar = 1'b0; e.MI = 1'b1; e.ALU_flags = 6'd31;
        apply(1'b0, 16'h3E40, e, "eo_mi_flags");

        for (int s = 0; s < 8; s++) begin
            e = C_IDLE;
            e.ALU_flags = 6'(s << 3);
            case (s)
                0: e.PO_bar  = 1'b0;
                1: e.IOH_bar = 1'b0;
                2: e.IOL_bar = 1'b0;
                3: e.RO      = 1'b1;
                4: e.XO_bar  = 1'b0;
                5: e.YO_bar  = 1'b0;
                6: e.DO      = 1'b1;
                default: ;
            endcase
            apply(1'b0, 16'h8000 | 16'(s << 12), e, $sformatf("src_%0d", s));
        end

        for (int d = 0; d < 8; d++) begin
            e = C_IDLE;
            e.EO_bar = 1'b0;
            case (d)
                1: e.MI     = 1'b1;
                2: e.II_bar = 1'b0;
                3: e.RI     = 1'b1;
                4: e.XI_bar = 1'b0;
                5: e.YI_bar = 1'b0;
                6: e.DI     = 1'b1;
                default: ;
            endcase
            apply(1'b0, 16'(d << 6), e, $sformatf("dst_%0d", d));
        end

        e = C_IDLE; e.IOH_bar = 1'b0; e.RT = 1'b1; e.PP = 1'b1; e.JC = 1'b1;
        e.ALU_flags = 6'd14;
        apply(1'b0, 16'h9C20, e, "ioh_rt_pp_jc");

        // EO with bits 11:10 set must not leak into RT/PP; all jumps plus reserved bits.
        e = C_IDLE; e.EO_bar = 1'b0; e.JC = 1'b1; e.JZ = 1'b1; e.JGT = 1'b1; e.JLT = 1'b1;
        e.ALU_flags = 6'd6;
        apply(1'b0, 16'h0C3F, e, "eo_blocks_rt_pp_jumps");

        e = C_IDLE; e.JZ = 1'b1; e.JLT = 1'b1; e.DI = 1'b1; e.ALU_flags = 6'd56;
        apply(1'b0, 16'hF194, e, "none_src_di_jz_jlt");

        e = C_IDLE; e.RO = 1'b1; e.YI_bar = 1'b0; e.PP = 1'b1; e.ALU_flags = 6'd26;
        apply(1'b0, 16'hB540, e, "ro_yi_pp");
        apply(1'b1, 16'hB540, C_IDLE, "reset_mid_op");
        apply(1'b0, 16'hB540, e, "reset_release");

        // Asynchronous reset: outputs must go idle without any clock edge.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (act !== C_IDLE) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", act, C_IDLE);
        end
        reset = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
